register_file: RTL and testbench

//   General-purpose register file for the single-cycle processor datapath.
//   Two combinational read ports (RS1, RS2) and one synchronous write port (RD).

---
 rtl/register_file.sv | 77 +++++++
 tb/tb_register_file.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file
//   General-purpose register file for the single-cycle datapath: two
//   combinational read ports and one synchronous write port. Every register,
//   r0 included, is ordinary storage (no hardwired zero).
//
//   Optional feature macro: RF_BYPASS_EN
//     defined   -> a read whose index matches an enabled, non-reset write in
//                  the same cycle returns DataIn combinationally.
//     undefined -> reads always return the stored contents.
//
// Parameters
//   DATA_W  width of each register and of all data ports
//   ADDR_W  register index width; depth is 2**ADDR_W
//
// Ports
//   CLK     in   1       clock, rising edge
//   RSTn    in   1       synchronous reset, active-low (clears all registers)
//   WrEn    in   1       write enable
//   RS1     in   ADDR_W  read port 1 index
//   RS2     in   ADDR_W  read port 2 index
//   RD      in   ADDR_W  write index
//   DataIn  in   DATA_W  write data
//   Out1    out  DATA_W  contents of register RS1
//   Out2    out  DATA_W  contents of register RS2
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] RS1,
    input  logic [ADDR_W-1:0] RS2,
    input  logic [ADDR_W-1:0] RD,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] Out1,
    output logic [DATA_W-1:0] Out2
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    // Reset takes priority over a coincident write.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_regs <= '{default: '0};
        end else if (WrEn) begin
            r_regs[RD] <= DataIn;
        end
    end

    assign w_rd1 = r_regs[RS1];
    assign w_rd2 = r_regs[RS2];

`ifdef RF_BYPASS_EN
    logic w_fwd1;
    logic w_fwd2;

    // Forward the in-flight write so a same-cycle read sees the new value.
    assign w_fwd1 = WrEn && RSTn && (RD == RS1);
    assign w_fwd2 = WrEn && RSTn && (RD == RS2);

    always_comb begin
        Out1 = w_fwd1 ? DataIn : w_rd1;
        Out2 = w_fwd2 ? DataIn : w_rd2;
    end
`else
    always_comb begin
        Out1 = w_rd1;
        Out2 = w_rd2;
    end
`endif

endmodule

// File: tb/tb_register_file.sv
// tb_register_file
//   Self-checking bench for register_file. A reference array tracks what each
//   register should hold; expected read values are queued when a read index
//   is driven and compared once the combinational outputs have settled.
module tb_register_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int NREGS  = 16;

    logic              CLK;
    logic              RSTn;
    logic              WrEn;
    logic [ADDR_W-1:0] RS1;
    logic [ADDR_W-1:0] RS2;
    logic [ADDR_W-1:0] RD;
    logic [DATA_W-1:0] DataIn;
    logic [DATA_W-1:0] Out1;
    logic [DATA_W-1:0] Out2;

    register_file #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_dut (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .WrEn  (WrEn),
        .RS1   (RS1),
        .RS2   (RS2),
        .RD    (RD),
        .DataIn(DataIn),
        .Out1  (Out1),
        .Out2  (Out2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [DATA_W-1:0] e1;
        logic [DATA_W-1:0] e2;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] model [NREGS];
    int                n_checks = 0;
    int                n_errors = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive read indices, queue the expectation, then compare after settling.
    task automatic drive_read(input string tag, input logic [ADDR_W-1:0] a,
                              input logic [ADDR_W-1:0] b,
                              input logic [DATA_W-1:0] e1,
                              input logic [DATA_W-1:0] e2);
        exp_t e;
        RS1  = a;
        RS2  = b;
        e.e1 = e1;
        e.e2 = e2;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        check({tag, "_out1"}, Out1, e.e1);
        check({tag, "_out2"}, Out2, e.e2);
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < NREGS; a++) begin
            for (int b = 0; b < NREGS; b++) begin
                drive_read(tag, a[ADDR_W-1:0], b[ADDR_W-1:0], model[a], model[b]);
            end
        end
    endtask

    task automatic wr(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        RD     = addr;
        DataIn = data;
        WrEn   = 1'b1;
        tick();
        model[addr] = data;
        WrEn   = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NREGS; i++) model[i] = '0;
    endtask

    initial begin
        logic [DATA_W-1:0] fib [9];
        fib = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13, 32'd21, 32'd34};

        RSTn   = 1'b0;
        WrEn   = 1'b0;
        RS1    = '0;
        RS2    = '0;
        RD     = '0;
        DataIn = '0;
        clear_model();

        // Reset clears everything.
        tick();
        RSTn = 1'b1;
        sweep("reset");

        // Disabled writes leave r0 untouched.
        RD     = 4'd0;
        DataIn = 32'd42;
        WrEn   = 1'b0;
        repeat (3) tick();
        drive_read("wren_low", 4'd0, 4'd0, model[0], model[0]);

        // Fibonacci fill of r0..r8; r9..r15 stay zero.
        for (int i = 0; i < 9; i++) wr(i[ADDR_W-1:0], fib[i]);
        sweep("fill");

        // Full-width value survives on both ports.
        wr(4'd3, 32'hFFFF_FFFF);
        drive_read("full_width", 4'd3, 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Same-cycle write/read collision on r5.
        RD     = 4'd5;
        DataIn = 32'd99;
        WrEn   = 1'b1;
`ifdef RF_BYPASS_EN
        drive_read("collide_pre", 4'd5, 4'd3, 32'd99, model[3]);
`else
        drive_read("collide_pre", 4'd5, 4'd3, model[5], model[3]);
`endif
        tick();
        model[5] = 32'd99;
        WrEn = 1'b0;
        drive_read("collide_post", 4'd5, 4'd5, 32'd99, 32'd99);
        sweep("after_collide");

        // Reset wins over a coincident write.
        RD     = 4'd2;
        DataIn = 32'd7;
        WrEn   = 1'b1;
        RSTn   = 1'b0;
        tick();
        clear_model();
        RSTn = 1'b1;
        WrEn = 1'b0;
        drive_read("reset_wins", 4'd2, 4'd2, 32'd0, 32'd0);
        sweep("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: run did not complete within bound");
        $fatal(1);
    end

endmodule
